bka_16_sub_pipe: RTL and testbench

//  Pipelined 16-bit subtractor with a Brent-Kung borrow network: q = a - b - bin (mod 2^16).

---
 rtl/bka_16_sub_pipe_pkg.sv | 59 +++++
 rtl/bka16_pg_tree_s1.sv | 35 +++
 rtl/bka_16_sub_pipe.sv | 139 +++++++++++++
 tb/tb_bka_16_sub_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bka_16_sub_pipe_pkg.sv
// ============================================================================
// Module  : bka_16_sub_pipe_pkg
// Brief   : Shared types, widths and prefix-cell functions for the BK subtractor.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bka_16_sub_pipe_pkg;

  localparam int unsigned W   = 16;
  localparam int unsigned LAT = 2;

  // Field order lets a {g, p} concatenation be used directly as a pg_t.
  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  typedef struct packed {
    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [7:0]   p2;
    logic [7:0]   g2;
    logic [3:0]   p4;
    logic [3:0]   g4;
    logic         cin;
    logic         a_msb;
    logic         b_msb;
  } s1_t;

  typedef struct packed {
    logic [W-1:0] q;
    logic         borrow_out;
    logic         zero;
    logic         neg;
    logic         ovf;
  } s2_t;

  function automatic pg_t pg_onebit(input logic x, input logic y);
    pg_t r;
    r.p = x ^ y;
    r.g = x & y;
    return r;
  endfunction

  function automatic pg_t pg_blackcell(input pg_t hi, input pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  function automatic logic pg_graycell(input pg_t hi, input logic c_lo);
    return hi.g | (hi.p & c_lo);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bka16_pg_tree_s1.sv
// ============================================================================
// Module  : bka16_pg_tree_s1
// Brief   : First two Brent-Kung up-sweep levels: 2-bit and 4-bit group p/g.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bka16_pg_tree_s1
  import bka_16_sub_pipe_pkg::*;
(
  input  logic [W-1:0] p,
  input  logic [W-1:0] g,
  output logic [7:0]   p2,
  output logic [7:0]   g2,
  output logic [3:0]   p4,
  output logic [3:0]   g4
);

  for (genvar i = 0; i < 8; i++) begin : g_pair
    pg_t pair_pg;
    assign pair_pg = pg_blackcell({g[2*i+1], p[2*i+1]}, {g[2*i], p[2*i]});
    assign p2[i]   = pair_pg.p;
    assign g2[i]   = pair_pg.g;
  end

  for (genvar j = 0; j < 4; j++) begin : g_quad
    pg_t quad_pg;
    assign quad_pg = pg_blackcell({g2[2*j+1], p2[2*j+1]}, {g2[2*j], p2[2*j]});
    assign p4[j]   = quad_pg.p;
    assign g4[j]   = quad_pg.g;
  end

endmodule

`default_nettype wire

// File: rtl/bka_16_sub_pipe.sv
// ============================================================================
// Module  : bka_16_sub_pipe
// Brief   : 2-stage valid/ready pipelined a - b - bin with BK borrow network.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bka_16_sub_pipe
  import bka_16_sub_pipe_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] q,
  output logic         borrow_out,
  output logic         zero,
  output logic         neg,
  output logic         ovf
);

  logic         s1_valid_q, s1_valid_d;
  logic         s2_valid_q, s2_valid_d;
  s1_t          s1_q, s1_d;
  s2_t          s2_q, s2_d;

  logic         s1_adv, s2_adv, accept;
  logic [W-1:0] bit_p, bit_g;
  logic [7:0]   p2, g2;
  logic [3:0]   p4, g4;

  // Subtraction as a + ~b + !bin.
  for (genvar i = 0; i < W; i++) begin : g_bit
    pg_t b_pg;
    assign b_pg     = pg_onebit(a[i], ~b[i]);
    assign bit_p[i] = b_pg.p;
    assign bit_g[i] = b_pg.g;
  end

  bka16_pg_tree_s1 u_pg_tree_s1 (
    .p  (bit_p),
    .g  (bit_g),
    .p2 (p2),
    .g2 (g2),
    .p4 (p4),
    .g4 (g4)
  );

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid & s1_adv;

  always_comb begin
    s1_valid_d = s1_adv ? accept : s1_valid_q;
    s1_d       = s1_q;
    if (accept) begin
      s1_d.p     = bit_p;
      s1_d.g     = bit_g;
      s1_d.p2    = p2;
      s1_d.g2    = g2;
      s1_d.p4    = p4;
      s1_d.g4    = g4;
      s1_d.cin   = ~bin;
      s1_d.a_msb = a[W-1];
      s1_d.b_msb = b[W-1];
    end
  end

  pg_t          grp8_lo, grp8_hi, grp16;
  logic [W:0]   c;      // c[i+1] is the carry out of bit i; c[0] is the carry in
  logic [W-1:0] diff;

  always_comb begin
    grp8_lo = pg_blackcell({s1_q.g4[1], s1_q.p4[1]}, {s1_q.g4[0], s1_q.p4[0]});
    grp8_hi = pg_blackcell({s1_q.g4[3], s1_q.p4[3]}, {s1_q.g4[2], s1_q.p4[2]});
    grp16   = pg_blackcell(grp8_hi, grp8_lo);

    c       = '0;
    c[0]    = s1_q.cin;
    c[2]    = pg_graycell({s1_q.g2[0], s1_q.p2[0]}, c[0]);
    c[4]    = pg_graycell({s1_q.g4[0], s1_q.p4[0]}, c[0]);
    c[8]    = pg_graycell(grp8_lo, c[0]);
    c[16]   = pg_graycell(grp16, c[0]);
    c[12]   = pg_graycell({s1_q.g4[2], s1_q.p4[2]}, c[8]);
    c[6]    = pg_graycell({s1_q.g2[2], s1_q.p2[2]}, c[4]);
    c[10]   = pg_graycell({s1_q.g2[4], s1_q.p2[4]}, c[8]);
    c[14]   = pg_graycell({s1_q.g2[6], s1_q.p2[6]}, c[12]);
    for (int k = 0; k < 8; k++) begin
      c[2*k+1] = pg_graycell({s1_q.g[2*k], s1_q.p[2*k]}, c[2*k]);
    end
    diff = s1_q.p ^ c[W-1:0];
  end

  // Odd-pair and odd-bit generates only feed the S1 tree, not the S2 carries.
  logic s2_unused;
  assign s2_unused = ^{s1_q.g, s1_q.p2, s1_q.g2};

  always_comb begin
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_d       = s2_q;
    if (s2_adv && s1_valid_q) begin
      s2_d.q          = diff;
      s2_d.borrow_out = ~c[W];
      s2_d.zero       = (diff == '0);
      s2_d.neg        = diff[W-1];
      s2_d.ovf        = (s1_q.a_msb != s1_q.b_msb) && (diff[W-1] != s1_q.a_msb);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign q          = s2_q.q;
  assign borrow_out = s2_q.borrow_out;
  assign zero       = s2_q.zero;
  assign neg        = s2_q.neg;
  assign ovf        = s2_q.ovf;

endmodule

`default_nettype wire

// File: tb/tb_bka_16_sub_pipe.sv
// ============================================================================
// Module  : tb_bka_16_sub_pipe
// Brief   : Self-checking bench for bka_16_sub_pipe against a queue-based model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bka_16_sub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] a, b;
  logic        bin;
  logic        out_valid, out_ready;
  logic [15:0] q;
  logic        borrow_out, zero, neg, ovf;

  always #5 clk = ~clk;

  bka_16_sub_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .q          (q),
    .borrow_out (borrow_out),
    .zero       (zero),
    .neg        (neg),
    .ovf        (ovf)
  );

  typedef struct {
    logic [15:0] q;
    logic        bo;
    logic        z;
    logic        n;
    logic        v;
    int          acc;
  } exp_t;

  exp_t mq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_out  = 0;

  function automatic exp_t ref_sub(input logic [15:0] x, input logic [15:0] y, input logic bi);
    exp_t        r;
    logic [16:0] d;
    d     = {1'b0, x} - {1'b0, y} - {16'd0, bi};
    r.q   = d[15:0];
    r.bo  = d[16];
    r.z   = (d[15:0] == 16'd0);
    r.n   = d[15];
    r.v   = (x[15] != y[15]) && (d[15] != x[15]);
    r.acc = 0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rnd16();
    logic [15:0] sp [4];
    sp[0] = 16'h0000; sp[1] = 16'hFFFF; sp[2] = 16'h8000; sp[3] = 16'h7FFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  // Model: in-flight results in order; the front is visible two cycles after its accept.
  initial begin
    forever begin
      logic exp_ov, exp_rdy;
      exp_t e;
      @(negedge clk);
      #1;
      exp_ov  = (mq.size() > 0) && (cyc >= mq[0].acc + 2);
      exp_rdy = (mq.size() < 2) || out_ready;
      if (!rst) begin
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (exp_ov && out_valid) begin
          chk("q", 32'(q), 32'(mq[0].q));
          chk("borrow_out", 32'(borrow_out), 32'(mq[0].bo));
          chk("zero", 32'(zero), 32'(mq[0].z));
          chk("neg", 32'(neg), 32'(mq[0].n));
          chk("ovf", 32'(ovf), 32'(mq[0].v));
        end
        if (exp_ov && out_ready) begin
          void'(mq.pop_front());
          n_out++;
        end
        if (in_valid && exp_rdy) begin
          e     = ref_sub(a, b, bin);
          e.acc = cyc;
          mq.push_back(e);
        end
      end else begin
        mq.delete();
      end
      cyc++;
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic bi, output int n);
    logic rdy;
    a = x; b = y; bin = bi; in_valid = 1'b1;
    n = 0;
    do begin
      #1;
      rdy = in_ready;
      @(negedge clk);
      n++;
    end while (!rdy && n < 200);
    if (!rdy) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic directed(input string nm, input logic [15:0] x, input logic [15:0] y,
                          input logic bi, input logic [15:0] eq, input logic [3:0] ef);
    int n;
    send(x, y, bi, n);
    #1;
    chk({nm, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk({nm, "_lat2"}, 32'(out_valid), 32'd1);
    chk({nm, "_q"}, 32'(q), 32'(eq));
    chk({nm, "_flags"}, 32'({borrow_out, zero, neg, ovf}), 32'(ef));
    @(negedge clk);
  endtask

  initial begin
    int          n, total, acc_cnt;
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [15:0] held;
    exp_t        e;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_flags", 32'({borrow_out, zero, neg, ovf}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // flags = {borrow_out, zero, neg, ovf}
    directed("t1_5m3",     16'h0005, 16'h0003, 1'b0, 16'h0002, 4'b0000);
    directed("t2_0m1",     16'h0000, 16'h0001, 1'b0, 16'hFFFF, 4'b1010);
    directed("t3_ovf",     16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b0001);
    directed("t3_zero",    16'h1234, 16'h1233, 1'b1, 16'h0000, 4'b0100);
    directed("b_eq_bin",   16'h1234, 16'h1234, 1'b1, 16'hFFFF, 4'b1010);
    directed("b_allones",  16'h0005, 16'hFFFF, 1'b1, 16'h0005, 4'b1000);
    directed("b_zeros",    16'h0000, 16'h0000, 1'b0, 16'h0000, 4'b0100);
    directed("b_negovf",   16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 4'b1011);

    // Back-to-back stream at full throughput
    total = 0;
    for (int i = 0; i < 100; i++) begin
      send(rnd16(), rnd16(), 1'($urandom), n);
      total += n;
    end
    chk("t4_throughput", 32'(total), 32'd100);
    repeat (3) @(negedge clk);
    chk("t4_drained", 32'(mq.size()), 32'd0);

    // Stall: out_ready low for 5 cycles while offering 4 vectors
    for (int i = 0; i < 4; i++) begin va[i] = rnd16(); vb[i] = rnd16(); end
    out_ready = 1'b0;
    acc_cnt = 0;
    n = n_out;
    for (int k = 0; k < 5; k++) begin
      a = va[acc_cnt % 4]; b = vb[acc_cnt % 4]; bin = 1'b0; in_valid = 1'b1;
      #1;
      if (in_ready) acc_cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("t5_accepted", 32'(acc_cnt), 32'd2);
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    e = ref_sub(va[0], vb[0], 1'b0);
    held = q;
    chk("t5_q_front", 32'(held), 32'(e.q));
    @(negedge clk);
    #1;
    chk("t5_q_stable", 32'(q), 32'(held));
    @(negedge clk);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_drain_count", 32'(n_out - n), 32'd2);
    chk("t5_drain_empty", 32'(mq.size()), 32'd0);

    // Reset with both stages full
    out_ready = 1'b0;
    send(16'h1111, 16'h0001, 1'b0, n);
    send(16'h2222, 16'h0002, 1'b0, n);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_q", 32'(q), 32'd0);
    chk("t6_flags", 32'({borrow_out, zero, neg, ovf}), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    directed("t6_fresh", 16'h0100, 16'h0001, 1'b1, 16'h00FE, 4'b0000);

    // Random traffic with random back-pressure
    for (int k = 0; k < 400; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = 1'($urandom);
      a = rnd16(); b = rnd16(); bin = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("t7_drained", 32'(mq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
